// File: rtl/design_sel_ctrl.sv
// Project-switch sequencer: synchronizes and debounces the pad design select,
// then runs a blank / reset / release sequence before the mux follows it.
module design_sel_ctrl #(
   parameter int STABLE_CYCLES = 8,
   parameter int SETTLE_CYCLES = 4,
   parameter int RST_CYCLES    = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] design_sel_pad,
   input  logic       soft_rst_pad,
   output logic [2:0] design_sel_out,
   output logic       proj_rst,
   output logic       mux_blank,
   output logic       busy,
   output logic       switch_done
);

   localparam int CNT_W  = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam int PH_MAX = (SETTLE_CYCLES > RST_CYCLES) ? SETTLE_CYCLES : RST_CYCLES;
   localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [PH_W-1:0]  SETTLE_LOAD = PH_W'(SETTLE_CYCLES - 1);
   localparam logic [PH_W-1:0]  RST_LOAD    = PH_W'(RST_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_BLANK, S_RESET, S_RELEASE} state_t;

   logic [2:0]       sel_meta, sel_sync;
   logic             soft_meta, soft_sync, soft_sync_q;
   logic [2:0]       cand;
   logic [CNT_W-1:0] cnt;
   logic             stable, soft_edge;

   state_t           state, state_nxt;
   logic [PH_W-1:0]  ph, ph_nxt;
   logic [2:0]       target, target_nxt, sel_nxt;
   logic             done_nxt;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_meta    <= '0;
         sel_sync    <= '0;
         soft_meta   <= 1'b0;
         soft_sync   <= 1'b0;
         soft_sync_q <= 1'b0;
      end else begin
         sel_meta    <= design_sel_pad;
         sel_sync    <= sel_meta;
         soft_meta   <= soft_rst_pad;
         soft_sync   <= soft_meta;
         soft_sync_q <= soft_sync;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cand <= '0;
         cnt  <= '0;
      end else if (sel_sync != cand) begin
         cand <= sel_sync;
         cnt  <= '0;
      end else if (cnt != CNT_LAST) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign stable    = (sel_sync == cand) && (cnt == CNT_LAST);
   assign soft_edge = soft_sync & ~soft_sync_q;

   // NOTE: every always_comb output gets a default first so no path leaves
   // a signal unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt  = state;
      ph_nxt     = ph;
      target_nxt = target;
      sel_nxt    = design_sel_out;
      done_nxt   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (stable && (cand != design_sel_out)) begin
               target_nxt = cand;
               state_nxt  = S_BLANK;
               ph_nxt     = SETTLE_LOAD;
            end else if (soft_edge) begin
               target_nxt = design_sel_out;
               state_nxt  = S_BLANK;
               ph_nxt     = SETTLE_LOAD;
            end
         end
         S_BLANK: begin
            if (ph == '0) begin
               state_nxt = S_RESET;
               ph_nxt    = RST_LOAD;
               sel_nxt   = target;
            end else begin
               ph_nxt = ph - PH_W'(1);
            end
         end
         S_RESET: begin
            if (ph == '0) begin
               state_nxt = S_RELEASE;
               ph_nxt    = SETTLE_LOAD;
            end else begin
               ph_nxt = ph - PH_W'(1);
            end
         end
         S_RELEASE: begin
            if (ph == '0) begin
               state_nxt = S_IDLE;
               ph_nxt    = '0;
               done_nxt  = 1'b1;
            end else begin
               ph_nxt = ph - PH_W'(1);
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state into flops so pads see no glitches.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= S_RESET;
         ph             <= RST_LOAD;
         target         <= '0;
         design_sel_out <= '0;
         proj_rst       <= 1'b1;
         mux_blank      <= 1'b1;
         busy           <= 1'b1;
         switch_done    <= 1'b0;
      end else begin
         state          <= state_nxt;
         ph             <= ph_nxt;
         target         <= target_nxt;
         design_sel_out <= sel_nxt;
         proj_rst       <= (state_nxt == S_RESET);
         mux_blank      <= (state_nxt != S_IDLE);
         busy           <= (state_nxt != S_IDLE);
         switch_done    <= done_nxt;
      end
   end

endmodule

// File: tb/tb_design_sel_ctrl.sv
// Directed bench for design_sel_ctrl: power-on, switching, glitch rejection,
// back-to-back switches, soft reset and mid-sequence async reset.
`timescale 1ns/1ps
module tb_design_sel_ctrl;

   localparam int SETTLE = 4;
   localparam int RSTLEN = 16;
   localparam int SEQLEN = 2 * SETTLE + RSTLEN;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] design_sel_pad = 3'b000;
   logic       soft_rst_pad = 1'b0;
   logic [2:0] design_sel_out;
   logic       proj_rst, mux_blank, busy, switch_done;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;

   design_sel_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .design_sel_pad (design_sel_pad),
      .soft_rst_pad   (soft_rst_pad),
      .design_sel_out (design_sel_out),
      .proj_rst       (proj_rst),
      .mux_blank      (mux_blank),
      .busy           (busy),
      .switch_done    (switch_done)
   );

   always @(negedge clk) if (switch_done === 1'b1) done_cnt <= done_cnt + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_blank(output int lat);
      lat = 0;
      while (mux_blank !== 1'b1 && lat < 60) begin
         tick();
         lat++;
      end
   endtask

   // Called at the first sample after BLANK entry; ends one cycle after switch_done.
   // mode 1 changes the pad select at RESET entry, mode 2 raises soft reset during RESET.
   task automatic check_sequence(input string tag, input logic [2:0] old_sel,
                                 input logic [2:0] new_sel, input int mode,
                                 input logic [2:0] hook_sel);
      int nb, nr, nl, bad, done0;
      nb = 0; nr = 0; nl = 0; bad = 0; done0 = done_cnt;
      while (mux_blank === 1'b1 && proj_rst !== 1'b1 && nb < 100) begin
         if (design_sel_out !== old_sel || busy !== 1'b1) bad++;
         tick();
         nb++;
      end
      check({tag, " blank_len"}, nb, SETTLE);
      check({tag, " sel_at_reset"}, design_sel_out, new_sel);
      if (mode == 1) design_sel_pad = hook_sel;
      else if (mode == 2) soft_rst_pad = 1'b1;
      while (proj_rst === 1'b1 && nr < 100) begin
         if (mux_blank !== 1'b1 || busy !== 1'b1 || design_sel_out !== new_sel) bad++;
         tick();
         nr++;
      end
      check({tag, " rst_len"}, nr, RSTLEN);
      if (mode == 2) soft_rst_pad = 1'b0;
      while (mux_blank === 1'b1 && nl < 100) begin
         if (proj_rst !== 1'b0 || busy !== 1'b1) bad++;
         tick();
         nl++;
      end
      check({tag, " release_len"}, nl, SETTLE);
      check({tag, " busy_len"}, nb + nr + nl, SEQLEN);
      check({tag, " done"}, switch_done, 1'b1);
      check({tag, " busy_end"}, busy, 1'b0);
      check({tag, " sel_end"}, design_sel_out, new_sel);
      check({tag, " phase_outputs"}, bad, 0);
      tick();
      check({tag, " done_off"}, switch_done, 1'b0);
      check({tag, " done_count"}, done_cnt - done0, 1);
   endtask

   // Called right at reset release.
   task automatic check_power_on(input string tag);
      int nr, nl, bad;
      nr = 0; nl = 0; bad = 0;
      while (proj_rst === 1'b1 && nr < 100) begin
         if (mux_blank !== 1'b1 || busy !== 1'b1 || design_sel_out !== 3'b000) bad++;
         tick();
         nr++;
      end
      check({tag, " rst_len"}, nr, RSTLEN);
      while (mux_blank === 1'b1 && nl < 100) begin
         if (proj_rst !== 1'b0 || busy !== 1'b1) bad++;
         tick();
         nl++;
      end
      check({tag, " release_len"}, nl, SETTLE);
      check({tag, " done"}, switch_done, 1'b1);
      check({tag, " busy_end"}, busy, 1'b0);
      check({tag, " sel"}, design_sel_out, 3'b000);
      check({tag, " phase_outputs"}, bad, 0);
      tick();
      check({tag, " done_off"}, switch_done, 1'b0);
   endtask

   initial begin
      int lat;
      int bad;

      // 1: power-on reset with pad 000
      tick();
      tick();
      check("rst proj_rst", proj_rst, 1'b1);
      check("rst mux_blank", mux_blank, 1'b1);
      check("rst busy", busy, 1'b1);
      check("rst switch_done", switch_done, 1'b0);
      check("rst sel", design_sel_out, 3'b000);
      rst = 1'b0;
      check_power_on("poweron");
      check("poweron idle_blank", mux_blank, 1'b0);

      // 3: a 5-cycle glitch to 011 is rejected
      design_sel_pad = 3'b011;
      repeat (5) tick();
      design_sel_pad = 3'b000;
      bad = 0;
      repeat (25) begin
         tick();
         if (mux_blank !== 1'b0 || proj_rst !== 1'b0 || busy !== 1'b0) bad++;
      end
      check("glitch quiet", bad, 0);
      check("glitch sel", design_sel_out, 3'b000);

      // 2: switch 000 -> 101
      design_sel_pad = 3'b101;
      tick();
      wait_blank(lat);
      check("sw101 latency", lat, 10);
      check_sequence("sw101", 3'b000, 3'b101, 0, 3'b000);

      // 4: switch to 001, pad moves to 010 during RESET
      design_sel_pad = 3'b001;
      tick();
      wait_blank(lat);
      check("sw001 latency", lat, 10);
      check_sequence("sw001", 3'b101, 3'b001, 1, 3'b010);
      check("b2b blank", mux_blank, 1'b1);
      check("b2b busy", busy, 1'b1);
      check_sequence("sw010", 3'b001, 3'b010, 0, 3'b000);

      // 5: move to 110, then soft reset with a dropped mid-sequence pulse
      design_sel_pad = 3'b110;
      tick();
      wait_blank(lat);
      check("sw110 latency", lat, 10);
      check_sequence("sw110", 3'b010, 3'b110, 0, 3'b000);
      soft_rst_pad = 1'b1;
      wait_blank(lat);
      soft_rst_pad = 1'b0;
      check("soft latency", lat, 3);
      check_sequence("soft", 3'b110, 3'b110, 2, 3'b000);
      bad = 0;
      repeat (15) begin
         tick();
         if (mux_blank !== 1'b0 || busy !== 1'b0) bad++;
      end
      check("soft no_second_seq", bad, 0);

      // 6: async reset during RELEASE of a switch to 111
      design_sel_pad = 3'b111;
      tick();
      wait_blank(lat);
      check("sw111 latency", lat, 10);
      lat = 0;
      while (proj_rst !== 1'b1 && lat < 100) begin tick(); lat++; end
      while (proj_rst === 1'b1 && lat < 100) begin tick(); lat++; end
      tick();
      check("sw111 in_release", mux_blank & ~proj_rst, 1'b1);
      check("sw111 sel", design_sel_out, 3'b111);
      #2 rst = 1'b1;
      #1;
      check("midrst proj_rst", proj_rst, 1'b1);
      check("midrst mux_blank", mux_blank, 1'b1);
      check("midrst busy", busy, 1'b1);
      check("midrst switch_done", switch_done, 1'b0);
      check("midrst sel", design_sel_out, 3'b000);
      tick();
      tick();
      rst = 1'b0;
      check_power_on("repower");
      check("repower next_blank", mux_blank, 1'b1);
      check_sequence("resw111", 3'b000, 3'b111, 0, 3'b000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
